// File: rtl/crossing_vote_filter.sv
// Temporal majority-vote filter for per-frame zebra-crossing verdicts, with hysteresis,
// a stalled-detector watchdog and a single-entry state-change event port.
module crossing_vote_filter #(
  parameter int unsigned HISTORY_LEN    = 8,
  parameter int unsigned ON_THRESH      = 5,
  parameter int unsigned OFF_THRESH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  localparam int unsigned VW = $clog2(HISTORY_LEN + 1),
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          det_valid,
  input  logic          det_crossing,
  input  logic [7:0]    det_blob_count,
  output logic          crossing_stable,
  output logic [VW-1:0] vote_count,
  output logic [7:0]    peak_blobs,
  output logic          stale,
  output logic [15:0]   frames_seen,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic          evt_state,
  output logic          evt_overrun
);

  if (!(OFF_THRESH < ON_THRESH && ON_THRESH <= HISTORY_LEN && HISTORY_LEN >= 2 &&
        HISTORY_LEN <= 32 && TIMEOUT_CYCLES >= 2)) begin : g_param_err
    $error("crossing_vote_filter: illegal parameter combination");
  end

  typedef enum logic {CLEAR, ASSERTED} state_t;

  state_t                 state_q, state_n;
  logic [HISTORY_LEN-1:0] hist_q, hist_n;
  logic [VW-1:0]          vote_n;
  logic [TW-1:0]          wd_q, wd_n;
  logic [7:0]             peak_n;
  logic                   stale_n;
  logic [15:0]            frames_n;
  logic                   evt_valid_n, evt_state_n, evt_overrun_n;
  logic                   expire, rise, fall;

  // Next-state: history, vote, FSM, watchdog, peak and event port
  always_comb begin
    hist_n        = hist_q;
    vote_n        = '0;
    state_n       = state_q;
    wd_n          = wd_q;
    peak_n        = peak_blobs;
    stale_n       = stale;
    frames_n      = frames_seen;
    evt_valid_n   = evt_valid;
    evt_state_n   = evt_state;
    evt_overrun_n = evt_overrun;
    rise          = 1'b0;
    fall          = 1'b0;
    expire        = !det_valid && (wd_q == TW'(TIMEOUT_CYCLES - 1));

    if (det_valid) begin
      hist_n   = {hist_q[HISTORY_LEN-2:0], det_crossing};
      wd_n     = '0;
      stale_n  = 1'b0;
      frames_n = frames_seen + 16'd1;
    end else if (wd_q != TW'(TIMEOUT_CYCLES)) begin
      wd_n = wd_q + TW'(1);
    end

    if (expire) begin
      hist_n  = '0;
      stale_n = 1'b1;
    end

    for (int unsigned i = 0; i < HISTORY_LEN; i++) begin
      vote_n = vote_n + VW'(hist_n[i]);
    end

    if (det_valid) begin
      if (state_q == CLEAR && vote_n >= VW'(ON_THRESH)) begin
        state_n = ASSERTED;
        rise    = 1'b1;
      end else if (state_q == ASSERTED && vote_n <= VW'(OFF_THRESH)) begin
        state_n = CLEAR;
        fall    = 1'b1;
      end
    end else if (expire && state_q == ASSERTED) begin
      state_n = CLEAR;
      fall    = 1'b1;
    end

    // Clear on fall/timeout takes priority over a new peak in the same frame
    if (det_valid && det_crossing && det_blob_count > peak_blobs) begin
      peak_n = det_blob_count;
    end
    if (fall || expire) begin
      peak_n = '0;
    end

    if (evt_valid && evt_ready) begin
      evt_valid_n = 1'b0;
    end
    if (rise || fall) begin
      evt_valid_n = 1'b1;
      evt_state_n = (state_n == ASSERTED);
      if (evt_valid && !evt_ready) begin
        evt_overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      hist_q      <= '0;
      vote_count  <= '0;
      wd_q        <= '0;
      peak_blobs  <= '0;
      stale       <= 1'b0;
      frames_seen <= '0;
      evt_valid   <= 1'b0;
      evt_state   <= 1'b0;
      evt_overrun <= 1'b0;
    end else begin
      state_q     <= state_n;
      hist_q      <= hist_n;
      vote_count  <= vote_n;
      wd_q        <= wd_n;
      peak_blobs  <= peak_n;
      stale       <= stale_n;
      frames_seen <= frames_n;
      evt_valid   <= evt_valid_n;
      evt_state   <= evt_state_n;
      evt_overrun <= evt_overrun_n;
    end
  end

  assign crossing_stable = (state_q == ASSERTED);

endmodule

// File: tb/tb_crossing_vote_filter.sv
// Bench for crossing_vote_filter: queue-based frame model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_crossing_vote_filter;

  localparam int unsigned L   = 8;
  localparam int unsigned ON  = 5;
  localparam int unsigned OFF = 2;
  localparam int unsigned T   = 100;
  localparam int unsigned VW  = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          det_valid = 1'b0;
  logic          det_crossing = 1'b0;
  logic [7:0]    det_blob_count = '0;
  logic          crossing_stable;
  logic [VW-1:0] vote_count;
  logic [7:0]    peak_blobs;
  logic          stale;
  logic [15:0]   frames_seen;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic          evt_state;
  logic          evt_overrun;

  int n_total = 0;
  int n_pass  = 0;

  crossing_vote_filter #(
    .HISTORY_LEN(L), .ON_THRESH(ON), .OFF_THRESH(OFF), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .det_valid(det_valid), .det_crossing(det_crossing), .det_blob_count(det_blob_count),
    .crossing_stable(crossing_stable), .vote_count(vote_count), .peak_blobs(peak_blobs),
    .stale(stale), .frames_seen(frames_seen),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_state(evt_state),
    .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model: newest-first queue of verdicts, cycles since last frame
  int m_hist[$];
  int m_vote = 0, m_peak = 0, m_since = 0, m_frames = 0;
  bit m_stable = 0, m_stale = 0, m_evt_valid = 0, m_evt_state = 0, m_ovr = 0;

  always @(posedge clk or negedge rst_n) begin
    bit changed, acc;
    if (!rst_n) begin
      m_hist.delete();
      m_vote = 0; m_peak = 0; m_since = 0; m_frames = 0;
      m_stable = 0; m_stale = 0; m_evt_valid = 0; m_evt_state = 0; m_ovr = 0;
    end else begin
      changed = 0;
      acc = m_evt_valid && evt_ready;
      if (det_valid) begin
        m_hist.push_front(int'(det_crossing));
        if (m_hist.size() > L) void'(m_hist.pop_back());
        m_vote = 0;
        foreach (m_hist[i]) m_vote += m_hist[i];
        m_since = 0;
        m_stale = 0;
        m_frames = (m_frames + 1) % 65536;
        if (det_crossing && int'(det_blob_count) > m_peak) m_peak = int'(det_blob_count);
        if (!m_stable && m_vote >= ON) begin
          m_stable = 1; changed = 1;
        end else if (m_stable && m_vote <= OFF) begin
          m_stable = 0; changed = 1; m_peak = 0;
        end
      end else begin
        m_since++;
        if (m_since == T) begin
          m_hist.delete();
          m_vote = 0; m_peak = 0; m_stale = 1;
          if (m_stable) begin m_stable = 0; changed = 1; end
        end
      end
      if (changed) begin
        if (m_evt_valid && !acc) m_ovr = 1;
        m_evt_valid = 1;
        m_evt_state = m_stable;
      end else if (acc) begin
        m_evt_valid = 0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_stable",    int'(crossing_stable), int'(m_stable));
      chk("m_vote",      int'(vote_count),      m_vote);
      chk("m_peak",      int'(peak_blobs),      m_peak);
      chk("m_stale",     int'(stale),           int'(m_stale));
      chk("m_frames",    int'(frames_seen),     m_frames);
      chk("m_evt_valid", int'(evt_valid),       int'(m_evt_valid));
      if (m_evt_valid) chk("m_evt_state", int'(evt_state), int'(m_evt_state));
      chk("m_overrun",   int'(evt_overrun),     int'(m_ovr));
    end
  end

  // Apply one cycle of inputs starting at a negedge; returns at the next negedge
  task automatic step(input bit v, input bit c, input int b, input bit r);
    det_valid      = v;
    det_crossing   = c;
    det_blob_count = 8'(b);
    evt_ready      = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, 0, r);
  endtask

  initial begin
    int blobs[5];
    int peaks[5];
    int zvotes[6];
    blobs  = '{3, 7, 5, 2, 9};
    peaks  = '{3, 7, 7, 7, 9};
    zvotes = '{5, 5, 5, 4, 3, 2};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_stable", int'(crossing_stable), 0);
    chk("rst_vote",   int'(vote_count), 0);
    chk("rst_evt",    int'(evt_valid), 0);
    chk("rst_frames", int'(frames_seen), 0);

    // Test 1: silence after reset, stale exactly at cycle 100
    idle(50, 1);
    chk("t1_stale50", int'(stale), 0);
    chk("t1_peak50",  int'(peak_blobs), 0);
    idle(49, 1);
    chk("t1_stale99", int'(stale), 0);
    idle(1, 1);
    chk("t1_stale100", int'(stale), 1);
    chk("t1_evt100",   int'(evt_valid), 0);

    // Tests 2 and 4: five crossing frames, rise after the fifth, peak tracking
    for (int i = 0; i < 5; i++) begin
      step(1, 1, blobs[i], 1);
      chk("t2_vote",   int'(vote_count), i + 1);
      chk("t4_peak",   int'(peak_blobs), peaks[i]);
      chk("t2_stable", int'(crossing_stable), (i == 4) ? 1 : 0);
    end
    chk("t2_stale",    int'(stale), 0);
    chk("t2_evtv",     int'(evt_valid), 1);
    chk("t2_evts",     int'(evt_state), 1);
    chk("t2_frames",   int'(frames_seen), 5);
    idle(1, 1);
    chk("t2_evt_drop", int'(evt_valid), 0);

    // Test 3: zero frames drain the window; fall on the sixth
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 1);
      chk("t3_vote",   int'(vote_count), zvotes[i]);
      chk("t3_stable", int'(crossing_stable), (i == 5) ? 0 : 1);
    end
    chk("t3_evtv",   int'(evt_valid), 1);
    chk("t3_evts",   int'(evt_state), 0);
    chk("t3_peak",   int'(peak_blobs), 0);
    chk("t3_frames", int'(frames_seen), 11);
    idle(1, 1);

    // Test 5: assert, then starve the detector
    for (int i = 0; i < 5; i++) step(1, 1, 4, 1);
    chk("t5_vote",   int'(vote_count), 5);
    chk("t5_stable", int'(crossing_stable), 1);
    idle(2, 1);
    chk("t5_peak",   int'(peak_blobs), 4);
    idle(97, 1);
    chk("t5_stale99",  int'(stale), 0);
    chk("t5_stable99", int'(crossing_stable), 1);
    idle(1, 1);
    chk("t5_stale",  int'(stale), 1);
    chk("t5_vote0",  int'(vote_count), 0);
    chk("t5_stab0",  int'(crossing_stable), 0);
    chk("t5_peak0",  int'(peak_blobs), 0);
    chk("t5_evtv",   int'(evt_valid), 1);
    chk("t5_evts",   int'(evt_state), 0);
    idle(1, 1);
    chk("t5_evt_acc", int'(evt_valid), 0);
    idle(20, 1);
    chk("t5_still_stale", int'(stale), 1);
    step(1, 1, 6, 1);
    chk("t5_unstale", int'(stale), 0);
    chk("t5_vote1",   int'(vote_count), 1);
    chk("t5_frames",  int'(frames_seen), 17);

    // Test 6: consumer stalled through a rise and a fall
    for (int i = 0; i < 4; i++) step(1, 1, 2, 0);
    chk("t6_rise",  int'(crossing_stable), 1);
    chk("t6_evtv1", int'(evt_valid), 1);
    chk("t6_ovr0",  int'(evt_overrun), 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    chk("t6_fall",  int'(crossing_stable), 0);
    chk("t6_evts",  int'(evt_state), 0);
    chk("t6_evtv2", int'(evt_valid), 1);
    chk("t6_ovr1",  int'(evt_overrun), 1);
    idle(1, 1);
    chk("t6_evt_acc", int'(evt_valid), 0);
    chk("t6_ovr_sticky", int'(evt_overrun), 1);
    chk("t6_frames", int'(frames_seen), 27);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ovr",    int'(evt_overrun), 0);
    chk("ar_frames", int'(frames_seen), 0);
    chk("ar_vote",   int'(vote_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
